// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types, constants and target-address helpers for pc_sequencer.
//   next_sel_e    - next-PC source select
//   JUMP_BIT      - lowest PC bit kept from pc_plus4 on a J/JAL
//   branch_target - pc_plus4 + (sign-extended 16-bit offset << 2)
//   jump_target   - {pc_plus4[top:28], 26-bit index, 2'b00}
// Helpers work on a 64-bit wide address; callers truncate to ADDR_W (ADDR_W <= 64),
// which gives the required mod-2^ADDR_W result.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR
    } next_sel_e;

    localparam int unsigned JUMP_BIT  = 28;
    localparam int unsigned PC_MAX_W  = 64;

    typedef logic [PC_MAX_W-1:0] wide_addr_t;

    function automatic wide_addr_t branch_target(input wide_addr_t pc_plus4,
                                                 input logic [15:0] imm);
        return pc_plus4 + {{(PC_MAX_W - 18){imm[15]}}, imm, 2'b00};
    endfunction

    function automatic wide_addr_t jump_target(input wide_addr_t pc_plus4,
                                               input logic [25:0] index);
        return {pc_plus4[PC_MAX_W-1:JUMP_BIT], index, 2'b00};
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with advisory compare.
//   clk, reset  - clock, synchronous active-high reset (clears pointer/count/flags only)
//   push        - write push_data at the top; overwrites the oldest entry when full
//   pop         - compare top entry with cmp_data and drop it; ignored when push wins? no:
//                 the caller never raises both, pop is checked first
//   push_data   - value to push (link address)
//   cmp_data    - value compared against the popped entry
//   hit         - registered pulse: popped entry equalled cmp_data
//   underflow   - registered pulse: pop while empty
//   overflow    - sticky: push while full, cleared only by reset
module return_addr_stack #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    input  logic [ADDR_W-1:0] cmp_data,
    output logic              hit,
    output logic              underflow,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];

    // ptr_q is the next write slot; the top of stack sits one below it.
    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hit_q, hit_d;
    logic             underflow_q, underflow_d;
    logic             overflow_q, overflow_d;
    logic             full, empty;

    assign top_idx = ptr_q - PTR_W'(1);
    assign full    = (count_q == CNT_W'(RAS_DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        hit_d       = 1'b0;
        underflow_d = 1'b0;
        overflow_d  = overflow_q;
        if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                hit_d   = (mem[top_idx] == cmp_data);
                ptr_d   = top_idx;
                count_d = count_q - CNT_W'(1);
            end
        end else if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            count_q     <= '0;
            hit_q       <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            hit_q       <= hit_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; count/pointer alone define validity.
    always_ff @(posedge clk) begin
        if (push && !pop && !reset) begin
            mem[ptr_q] <= push_data;
        end
    end

    assign hit       = hit_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered MIPS program counter with branch/jump/JAL/JR selection
// and a return-address stack.
//   clk, reset      - clock, synchronous active-high reset (overrides stall and controls)
//   stall           - hold PC and RAS, ignore all controls
//   ins_offset      - instruction bits [25:0]
//   zero_alu        - ALU zero flag
//   con_beq/bneq    - conditional branch controls
//   con_jump/jal/jr - J, JAL (link + push), JR (pop + compare)
//   jr_target       - register value for JR
//   pc, pc_plus4    - current PC and its link value
//   ras_hit/ras_underflow/ras_overflow - RAS status (see return_addr_stack)
// Optional: define PCSEQ_ALIGN_TRAP_EN to redirect misaligned JR/branch targets to
// RESET_PC and expose the align_fault pulse output.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [25:0]       ins_offset,
    input  logic              zero_alu,
    input  logic              con_beq,
    input  logic              con_bneq,
    input  logic              con_jump,
    input  logic              con_jal,
    input  logic              con_jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ras_hit,
    output logic              ras_underflow,
    output logic              ras_overflow
`ifdef PCSEQ_ALIGN_TRAP_EN
    ,
    output logic              align_fault
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] branch_tgt, jump_tgt, sel_tgt;
    logic              take_branch;
    logic              ras_push, ras_pop;
    next_sel_e         next_sel;

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign pc       = pc_q;

    assign branch_tgt  = ADDR_W'(branch_target(wide_addr_t'(pc_plus4), ins_offset[15:0]));
    assign jump_tgt    = ADDR_W'(jump_target(wide_addr_t'(pc_plus4), ins_offset));
    assign take_branch = (con_beq & zero_alu) | (con_bneq & ~zero_alu);

    always_comb begin
        next_sel = SEL_SEQ;
        if (con_jr) begin
            next_sel = SEL_JR;
        end else if (con_jump || con_jal) begin
            next_sel = SEL_JUMP;
        end else if (take_branch) begin
            next_sel = SEL_BRANCH;
        end
    end

    always_comb begin
        sel_tgt = pc_plus4;
        unique case (next_sel)
            SEL_JR:     sel_tgt = jr_target;
            SEL_JUMP:   sel_tgt = jump_tgt;
            SEL_BRANCH: sel_tgt = branch_tgt;
            default:    sel_tgt = pc_plus4;
        endcase
    end

`ifdef PCSEQ_ALIGN_TRAP_EN
    logic misaligned;
    logic align_fault_q;

    assign misaligned = ((next_sel == SEL_JR) || (next_sel == SEL_BRANCH)) &&
                        (sel_tgt[1:0] != 2'b00);
    assign pc_d       = misaligned ? RESET_PC : sel_tgt;
    // A faulting JR leaves the stack untouched.
    assign ras_pop    = ~stall & con_jr & ~misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= ~stall & misaligned;
        end
    end

    assign align_fault = align_fault_q;
`else
    assign pc_d    = sel_tgt;
    assign ras_pop = ~stall & con_jr;
`endif

    // JR wins over JAL: only the pop happens.
    assign ras_push = ~stall & con_jal & ~con_jr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .cmp_data  (jr_target),
        .hit       (ras_hit),
        .underflow (ras_underflow),
        .overflow  (ras_overflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default build, RESET_PC = 32'h00A94FB2).
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h00A94FB2;
    localparam logic [31:0] SEQ_PC = 32'h00A94FB6;
    localparam logic [31:0] BR_PC  = 32'h00AB0DB6;
    localparam logic [31:0] J_PC   = 32'h00E9BE00;
    localparam logic [31:0] J_P4   = 32'h00E9BE04;

    logic        clk = 1'b0;
    logic        reset, stall, zero_alu;
    logic        con_beq, con_bneq, con_jump, con_jal, con_jr;
    logic [25:0] ins_offset;
    logic [31:0] jr_target, pc, pc_plus4;
    logic        ras_hit, ras_underflow, ras_overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W    (32),
        .RESET_PC  (RST_PC),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .ins_offset    (ins_offset),
        .zero_alu      (zero_alu),
        .con_beq       (con_beq),
        .con_bneq      (con_bneq),
        .con_jump      (con_jump),
        .con_jal       (con_jal),
        .con_jr        (con_jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_hit       (ras_hit),
        .ras_underflow (ras_underflow),
        .ras_overflow  (ras_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        stall    = 1'b0;
        zero_alu = 1'b0;
        con_beq  = 1'b0;
        con_bneq = 1'b0;
        con_jump = 1'b0;
        con_jal  = 1'b0;
        con_jr   = 1'b0;
        jr_target = 32'h0;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        ins_offset = 26'h3A6F80;
        reset      = 1'b0;
        clear_ctl();

        // 1. reset state and sequential advance
        do_reset();
        check("rst_pc", pc, RST_PC);
        check("rst_pc_plus4", pc_plus4, SEQ_PC);
        check("rst_hit", {31'b0, ras_hit}, 32'd0);
        check("rst_underflow", {31'b0, ras_underflow}, 32'd0);
        check("rst_overflow", {31'b0, ras_overflow}, 32'd0);
        step();
        check("seq_pc", pc, SEQ_PC);

        // 2. conditional branches
        do_reset(); con_bneq = 1'b1; zero_alu = 1'b0; step();
        check("bneq_taken", pc, BR_PC);
        do_reset(); con_bneq = 1'b1; zero_alu = 1'b1; step();
        check("bneq_not_taken", pc, SEQ_PC);
        do_reset(); con_beq = 1'b1; zero_alu = 1'b1; step();
        check("beq_taken", pc, BR_PC);
        do_reset(); con_beq = 1'b1; zero_alu = 1'b0; step();
        check("beq_not_taken", pc, SEQ_PC);

        // 3. jumps and priority
        do_reset(); con_jump = 1'b1; step();
        check("jump", pc, J_PC);
        do_reset(); con_jump = 1'b1; con_beq = 1'b1; zero_alu = 1'b1; step();
        check("jump_over_branch", pc, J_PC);
        do_reset(); con_jr = 1'b1; con_jump = 1'b1; jr_target = 32'h00002000; step();
        check("jr_over_jump", pc, 32'h00002000);
        check("jr_empty_underflow", {31'b0, ras_underflow}, 32'd1);
        clear_ctl(); step();
        check("underflow_one_cycle", {31'b0, ras_underflow}, 32'd0);

        // 4. JAL then JR, hit and miss
        do_reset(); con_jal = 1'b1; step();
        check("jal_pc", pc, J_PC);
        check("jal_no_hit", {31'b0, ras_hit}, 32'd0);
        clear_ctl(); con_jr = 1'b1; jr_target = SEQ_PC; step();
        check("jr_hit_pc", pc, SEQ_PC);
        check("jr_hit", {31'b0, ras_hit}, 32'd1);
        clear_ctl(); step();
        check("hit_one_cycle", {31'b0, ras_hit}, 32'd0);
        check("after_jr_seq", pc, 32'h00A94FBA);
        do_reset(); con_jal = 1'b1; step();
        clear_ctl(); con_jr = 1'b1; jr_target = 32'h00001000; step();
        check("jr_miss_pc", pc, 32'h00001000);
        check("jr_miss_hit", {31'b0, ras_hit}, 32'd0);
        check("jr_miss_underflow", {31'b0, ras_underflow}, 32'd0);

        // JAL and JR together: only the pop happens
        do_reset(); con_jal = 1'b1; step();
        con_jr = 1'b1; jr_target = SEQ_PC; step();
        check("jal_jr_pc", pc, SEQ_PC);
        check("jal_jr_hit", {31'b0, ras_hit}, 32'd1);
        clear_ctl(); con_jr = 1'b1; jr_target = SEQ_PC; step();
        check("jal_jr_no_push", {31'b0, ras_underflow}, 32'd1);

        // 5. overflow and drain
        do_reset(); con_jal = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("ovf_after_4", {31'b0, ras_overflow}, 32'd0);
        step();
        check("ovf_after_5", {31'b0, ras_overflow}, 32'd1);
        check("jal5_pc", pc, J_PC);
        clear_ctl(); con_jr = 1'b1; jr_target = J_P4;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("drain_hit_%0d", i), {31'b0, ras_hit}, 32'd1);
            check($sformatf("drain_no_uf_%0d", i), {31'b0, ras_underflow}, 32'd0);
        end
        check("drain_pc", pc, J_P4);
        step();
        check("drain5_hit", {31'b0, ras_hit}, 32'd0);
        check("drain5_underflow", {31'b0, ras_underflow}, 32'd1);
        check("ovf_sticky", {31'b0, ras_overflow}, 32'd1);

        // 6. stall, then reset during stall
        do_reset(); stall = 1'b1; con_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc_%0d", i), pc, RST_PC);
        end
        clear_ctl(); con_jal = 1'b1; step();
        check("pre_stall_jal", pc, J_PC);
        clear_ctl(); stall = 1'b1; con_jr = 1'b1; jr_target = SEQ_PC; step();
        check("stall_jr_pc", pc, J_PC);
        check("stall_jr_no_hit", {31'b0, ras_hit}, 32'd0);
        check("stall_jr_no_uf", {31'b0, ras_underflow}, 32'd0);
        reset = 1'b1; step();
        check("reset_in_stall_pc", pc, RST_PC);
        reset = 1'b0; clear_ctl(); con_jr = 1'b1; jr_target = SEQ_PC; step();
        check("post_reset_underflow", {31'b0, ras_underflow}, 32'd1);
        check("post_reset_no_hit", {31'b0, ras_hit}, 32'd0);
        check("post_reset_ovf", {31'b0, ras_overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
